// File: rtl/serial_pkg.sv
// Shared encodings and defaults for the serial transmit/receive blocks.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   localparam int CLKS_PER_BIT_9600 = 5208;

   // Even parity is the XOR of the byte; odd parity is its complement.
   function automatic logic parity_bit(input logic [7:0] value, input int mode);
      return (mode == PAR_ODD) ? ~(^value) : ^value;
   endfunction

endpackage

// File: rtl/serial_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module serial_baud_cnt #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   output logic             tick,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear || (count == LAST))
         count <= '0;
      else
         count <= count + 1'b1;
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// UART-style byte transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
module serial_tx
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
   parameter int PARITY       = PAR_NONE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] data_in,
   output logic       ready,
   output logic       tx,
   output logic       done
);

   localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] DONE_AT    = CNT_W'(CLKS_PER_BIT - 2);
   localparam bit               HAS_PARITY = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);

   state_t           state, state_next;
   logic [7:0]       shift, shift_next;
   logic [2:0]       bit_cnt, bit_cnt_next;
   logic             par, par_next;
   logic             tx_next, ready_next, done_next;
   logic             tick, baud_clear;
   logic [CNT_W-1:0] baud_count;

   // Holding the counter clear while idle makes every frame start at count 0.
   assign baud_clear = (state == IDLE) || tick;

   serial_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_W        (CNT_W)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (baud_clear),
      .tick  (tick),
      .count (baud_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         shift   <= '0;
         bit_cnt <= '0;
         par     <= 1'b0;
         tx      <= 1'b1;
         ready   <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         shift   <= shift_next;
         bit_cnt <= bit_cnt_next;
         par     <= par_next;
         tx      <= tx_next;
         ready   <= ready_next;
         done    <= done_next;
      end
   end

   always_comb begin
      state_next   = state;
      shift_next   = shift;
      bit_cnt_next = bit_cnt;
      par_next     = par;
      case (state)
         IDLE: begin
            if (enable) begin
               state_next = START;
               shift_next = data_in;
               par_next   = parity_bit(data_in, PARITY);
            end
         end
         START: begin
            if (tick)
               state_next = DATA;
         end
         DATA: begin
            if (tick) begin
               shift_next   = shift >> 1;
               bit_cnt_next = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7)
                  state_next = HAS_PARITY ? serial_pkg::PARITY : STOP;
            end
         end
         serial_pkg::PARITY: begin
            if (tick)
               state_next = STOP;
         end
         STOP: begin
            if (tick)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are derived from the next state so the registered line changes on the same edge.
   always_comb begin
      tx_next    = 1'b1;
      ready_next = 1'b0;
      case (state_next)
         IDLE:               ready_next = 1'b1;
         START:              tx_next    = 1'b0;
         DATA:               tx_next    = shift_next[0];
         serial_pkg::PARITY: tx_next    = par_next;
         STOP:               tx_next    = 1'b1;
         default:            ready_next = 1'b1;
      endcase
      done_next = (state == STOP) && (baud_count == DONE_AT);
   end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: three instances (no, even, odd parity) at 4 clocks per bit.
module tb_serial_tx;

   localparam int CPB = 4;

   typedef struct packed {
      logic tx;
      logic ready;
      logic done;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] en = 3'b000;
   logic [7:0] data_in = 8'h00;
   logic       tx0, tx1, tx2, ready0, ready1, ready2, done0, done1, done2;

   int   checks = 0;
   int   passes = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(0)) u_none (
      .clk(clk), .reset(reset), .enable(en[0]), .data_in(data_in),
      .ready(ready0), .tx(tx0), .done(done0));

   serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_even (
      .clk(clk), .reset(reset), .enable(en[1]), .data_in(data_in),
      .ready(ready1), .tx(tx1), .done(done1));

   serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_odd (
      .clk(clk), .reset(reset), .enable(en[2]), .data_in(data_in),
      .ready(ready2), .tx(tx2), .done(done2));

   function automatic exp_t obs(input int d);
      case (d)
         0:       return {tx0, ready0, done0};
         1:       return {tx1, ready1, done1};
         default: return {tx2, ready2, done2};
      endcase
   endfunction

   // Expected per-cycle line/ready/done for one frame, one entry per clock.
   task automatic push_frame(input logic [7:0] value, input int pmode);
      logic slot[$];
      exp_t e;
      slot.push_back(1'b0);
      for (int i = 0; i < 8; i++) slot.push_back(value[i]);
      if (pmode == 1) slot.push_back(^value);
      if (pmode == 2) slot.push_back(~(^value));
      slot.push_back(1'b1);
      for (int s = 0; s < slot.size(); s++) begin
         for (int c = 0; c < CPB; c++) begin
            e.tx    = slot[s];
            e.ready = 1'b0;
            e.done  = (s == slot.size() - 1) && (c == CPB - 1);
            sb.push_back(e);
         end
      end
   endtask

   task automatic push_idle(input int n);
      exp_t e;
      e = 3'b110;
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   task automatic applyStimulus(input int d, input logic [7:0] value);
      @(negedge clk);
      data_in = value;
      en      = 3'b000;
      en[d]   = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (obs(d) !== 3'b110)
            $display("[TB] FAIL reset_state dut%0d got tx/ready/done=%b want 110", d, obs(d));
         else passes++;
      end
      reset = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if (obs(0) !== 3'b110)
            $display("[TB] FAIL idle_hold cycle %0d got %b want 110", k, obs(0));
         else passes++;
      end
   endtask

   task automatic test_basic_frame();
      exp_t e;
      int   k;
      sb.delete();
      push_frame(8'h42, 0);
      push_idle(1);
      applyStimulus(0, 8'h42);
      k = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         k++;
         en = 3'b000;
         e  = sb.pop_front();
         checks++;
         if (obs(0) !== e)
            $display("[TB] FAIL basic_frame cycle %0d got %b want %b", k, obs(0), e);
         else passes++;
      end
   endtask

   task automatic test_parity(input int d);
      exp_t e;
      int   k;
      sb.delete();
      push_frame(8'h07, d);
      push_idle(1);
      applyStimulus(d, 8'h07);
      k = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         k++;
         en = 3'b000;
         e  = sb.pop_front();
         checks++;
         if (obs(d) !== e)
            $display("[TB] FAIL parity_frame mode %0d cycle %0d got %b want %b", d, k, obs(d), e);
         else passes++;
      end
   endtask

   task automatic test_busy_ignore();
      exp_t e;
      int   k;
      sb.delete();
      push_frame(8'hA5, 0);
      push_idle(10);
      applyStimulus(0, 8'hA5);
      k = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         k++;
         en = 3'b000;
         e  = sb.pop_front();
         checks++;
         if (obs(0) !== e)
            $display("[TB] FAIL busy_ignore cycle %0d got %b want %b", k, obs(0), e);
         else passes++;
         if (k == 10) begin
            en[0]   = 1'b1;
            data_in = 8'hFF;
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   k;
      sb.delete();
      for (int f = 0; f < 3; f++) begin
         push_frame(8'h01, 0);
         push_idle(1);
      end
      applyStimulus(0, 8'h01);
      k = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         k++;
         e = sb.pop_front();
         checks++;
         if (obs(0) !== e)
            $display("[TB] FAIL back_to_back cycle %0d got %b want %b", k, obs(0), e);
         else passes++;
         if (sb.size() == 0) en = 3'b000;
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      int   k;
      sb.delete();
      push_frame(8'h3C, 0);
      applyStimulus(0, 8'h3C);
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         en = 3'b000;
         e  = sb.pop_front();
         checks++;
         if (obs(0) !== e)
            $display("[TB] FAIL mid_reset_pre cycle %0d got %b want %b", c, obs(0), e);
         else passes++;
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (obs(0) !== 3'b110)
         $display("[TB] FAIL mid_reset_async got %b want 110", obs(0));
      else passes++;
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      push_frame(8'h3C, 0);
      push_idle(1);
      applyStimulus(0, 8'h3C);
      k = 0;
      while (sb.size() > 0) begin
         @(negedge clk);
         k++;
         en = 3'b000;
         e  = sb.pop_front();
         checks++;
         if (obs(0) !== e)
            $display("[TB] FAIL mid_reset_after cycle %0d got %b want %b", k, obs(0), e);
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_parity(1);
      test_parity(2);
      test_busy_ignore();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Byte-to-serial transmitter that consumes the 8-bit data/enable strobe produced by the switch/button input mux and returns the ready handshake that the mux waits on. It serializes each accepted byte as an asynchronous UART-style frame: start bit, 8 data bits LSB first, optional parity bit, then stop bit. The block sits between the input mux and the board's serial output pin.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535
PARITY, 0, 0 = none, 1 = even, 2 = odd; value 3 behaves as 0

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  request strobe from mux; sampled only while ready=1
data_in  input  8  byte to send; captured on the accepting edge
ready  output  1  1 = idle and able to accept a byte
tx  output  1  serial line; idles high
done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx=1, ready=1, done=0, bit counter=0, baud counter=0, shift register=0. All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: ready=1, tx=1. On an edge with enable=1:
  - latch data_in into the shift register;
  - go to START;
  - at that same edge, ready→0 and tx→0.
  - Latency from accepting edge to start-bit edge is 0 cycles.
- Each of START, DATA (per bit), PARITY and STOP holds tx for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and clears on every state or bit change.
- START → DATA.
- DATA: tx = shift[0]; the register shifts right at each bit boundary. After bit 7, go to PARITY if PARITY is 1 or 2, else to STOP.
- PARITY: tx = XOR of the latched byte (even), or its complement (odd).
- STOP: tx=1.
  - On the final STOP cycle done=1 for exactly one cycle.
  - The next edge returns to IDLE with ready=1.
- Frame length: 10*CLKS_PER_BIT cycles without parity, 11*CLKS_PER_BIT cycles with parity. This is measured from the accepting edge to the edge where ready is high again.
- enable while ready=0 is ignored; it is neither queued nor errored. The data_in value captured is the one at the accepting edge only.
- enable held high continuously: frames go back-to-back. The byte is re-accepted on the first IDLE cycle, so tx has 1 idle-high cycle between frames.
- Reset asserted mid-frame: the frame is aborted immediately, tx=1 and ready=1 asynchronously. No partial done pulse.
- Baud counter width is clog2(CLKS_PER_BIT). Bit counter is 3 bits and wraps only on the DATA→next-state transition.

Decomposition:
- Shared package serial_pkg holds:
  - state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit);
  - parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD);
  - default CLKS_PER_BIT_9600 = 5208.
- One sub-module is natural: serial_baud_cnt.
  - Parameter CLKS_PER_BIT.
  - Inputs clk, reset, clear.
  - Output tick, which is high on count == CLKS_PER_BIT-1.
  - A future serial receiver reuses it.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release → tx=1, ready=1, done=0. With enable=0 for 20 cycles, tx stays 1.
- Basic frame (CLKS_PER_BIT=4, PARITY=0): pulse enable with data_in=8'h42 → tx sequence per 4-cycle slot is 0 | 0,1,0,0,0,0,1,0 | 1. done pulses in cycle 40. ready returns high at cycle 40 after the accepting edge.
- Even parity (PARITY=1, CLKS_PER_BIT=4): data_in=8'h07 → parity slot tx=1, stop follows, frame is 44 cycles. With odd parity (PARITY=2) the same byte gives parity slot tx=0.
- Busy ignore: accept 8'hA5, then pulse enable with data_in=8'hFF at cycle 10 → transmitted bits are 1,0,1,0,0,1,0,1 only, and no second frame starts.
- Back-to-back: hold enable=1 with data_in=8'h01 → consecutive frames separated by exactly one idle-high cycle, and done pulses every 41 cycles.
- Mid-frame reset: drive reset=0 during data bit 3 → tx=1 and ready=1 within the same cycle with no clock edge. After release, a new 8'h3C frame transmits correctly.
